scoreboard_register_file: RTL and testbench
===========================================

# scoreboard_register_file

Parametrised successor to the KGP-RISC register file: a `DEPTH = 2**ADDR_WIDTH` entry, `NUM_READ`-port register file with same-cycle write-through bypass, a per-register pending scoreboard for the pipelined datapath, and a sequential clear engine. It sits between decode (reads, reservations) and writeback (writes). Hazard detection moves out of the control unit and into this block.

## Interface
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: register address width; `DEPTH = 2**ADDR_WIDTH`.
- `NUM_READ`, 2: number of read ports, minimum 1.
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and ignores writes and reservations.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `regWrite`  in  1: write enable.
- `writeAddr`  in  ADDR_WIDTH: write address.
- `writeData`  in  DATA_WIDTH: write data.
- `readAddr`  in  NUM_READ*ADDR_WIDTH: read addresses. Port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `readData`  out  NUM_READ*DATA_WIDTH: read data, combinational, packed the same way.
- `readReady`  out  NUM_READ: port i data is valid, meaning the register is not pending or is bypassed.
- `reserveEn`  in  1: request to mark `reserveAddr` pending.
- `reserveAddr`  in  ADDR_WIDTH: register to reserve.
- `reserveAck`  out  1: combinational; reservation accepted this cycle.
- `clearReq`  in  1: start the clear sweep.
- `clearBusy`  out  1: clear sweep in progress.

## Operation
- **Reset values:** all registers 0; all pending bits 0; FSM in IDLE; `clearBusy` = 0. `readData`, `readReady` and `reserveAck` follow combinationally from that state.
- **Write:**
  - `regWrite` writes `writeData` to `writeAddr` at the rising edge and clears `pending[writeAddr]`.
  - The write is ignored in CLEAR.
  - The write is ignored for address 0 when `ZERO_REG` = 1.
- **Read and bypass:**
  - If `regWrite` is 1, the FSM is IDLE, `writeAddr` == `readAddr[i]`, and the address is not a zeroed reg 0, then `readData[i]` = `writeData` and `readReady[i]` = 1.
  - Otherwise `readData[i]` = stored value and `readReady[i]` = !`pending[readAddr[i]]`.
  - Reg 0 with `ZERO_REG` = 1 always reads 0 with ready = 1.
- **Reservation:**
  - `reserveAck` = `reserveEn` & IDLE & !`pending[reserveAddr]`.
  - On ack, `pending[reserveAddr]` is set at the edge.
  - Reserving reg 0 with `ZERO_REG` = 1 acks but sets nothing.
  - Reserving an already-pending register is refused (`reserveAck` = 0), which blocks WAW hazards. The requester holds `reserveEn` until acked.
- **Simultaneous reserve and write, same address:**
  - A pending register cannot be acked, so no conflict arises in that case.
  - If the register is not pending, the write lands and the reservation is accepted. The pending bit ends at 1 (reserve wins).
- **Clear FSM, states IDLE and CLEAR:**
  - IDLE → CLEAR on `clearReq`; the index counter loads 0.
  - In CLEAR, each cycle zeroes `reg[index]`, clears `pending[index]` and increments `index`.
  - At `index` == DEPTH-1, the entry is cleared and the FSM returns to IDLE.
  - `clearReq` during CLEAR is ignored.
  - Writes and reservations in CLEAR are dropped. Producers must stall on `clearBusy`.
  - Reads in CLEAR return current, partially cleared contents without bypass.
- **Reset mid-operation:** `rst` at any point (including mid-sweep) returns the block to the reset values immediately.

## Timing
- Read latency is 0 cycles (combinational). Bypass makes a same-cycle write visible on the read ports.
- A write is stored at edge N and read from storage from cycle N+1.
- A reservation acked in cycle N makes `readReady` = 0 for that register from cycle N+1.
- Clear sweep: `clearReq` sampled at edge N sets `clearBusy` = 1 from N+1 through N+DEPTH. The FSM is back in IDLE at edge N+DEPTH, for a total of DEPTH cycles.
- `clearBusy` is registered, equal to (state == CLEAR).

## Structure
- **Package `rf_pkg`:** state encoding localparams `RF_IDLE` = 0 and `RF_CLEAR` = 1; default widths (32, 5, 2).
- **Sub-module `rf_scoreboard`:** holds the DEPTH pending bits with set (reserve), clear (write or sweep) and per-port lookup. It is instantiated once.
- **Top level:** storage array, bypass muxes, clear FSM and counter.

## Test plan
- **Reset:** assert `rst` mid-stream → all `readData` = 0, `readReady` all 1, `clearBusy` = 0, with no clock edge needed.
- **Write and bypass:**
  - Write r1 = 11 with `readAddr[0]` = 1 → `readData[0]` = 11 in the same cycle.
  - Next cycle, with `regWrite` = 0, it still reads 11.
  - Write r0 = 5 → r0 reads 0.
- **Scoreboard:**
  - Reserve r2 → ack = 1, and `readReady` for r2 = 0 the next cycle.
  - A second reserve of r2 → ack = 0.
  - Write r2 = 12 → bypass gives ready = 1 and data 12 that cycle; the following cycle r2 is not pending.
- **Clear:**
  - Preload r1..r31 with nonzero values, pulse `clearReq` → `clearBusy` high for exactly 32 cycles, then all registers read 0.
  - A write to r3 issued mid-sweep is dropped.
- **Reset mid-clear:** assert `rst` at sweep cycle 10 → `clearBusy` drops immediately, all registers 0, and the FSM accepts a new `clearReq`.
- **Multi-port:** with `NUM_READ` = 3, read r1, r2 and r1 simultaneously during a write to r1 → ports 0 and 2 bypass, port 1 returns stored r2.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboard register file: clear-FSM state
// encoding and default geometry.
package rf_pkg;

    localparam logic RF_IDLE  = 1'b0;
    localparam logic RF_CLEAR = 1'b1;

    typedef enum logic {
        ST_IDLE  = RF_IDLE,
        ST_CLEAR = RF_CLEAR
    } rf_state_e;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_READ   = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits. A bit is set by an accepted reservation and
// cleared by a writeback or by the clear sweep; set wins over clear so a
// same-cycle reserve and write to one register leaves it pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = RF_NUM_READ,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en_i,
    input  logic [ADDR_WIDTH-1:0]        set_addr_i,
    input  logic                         clr_en_i,
    input  logic [ADDR_WIDTH-1:0]        clr_addr_i,
    input  logic                         sweep_en_i,
    input  logic [ADDR_WIDTH-1:0]        sweep_addr_i,
    input  logic [ADDR_WIDTH-1:0]        query_addr_i,
    output logic                         query_pending_o,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr_i,
    output logic [NUM_READ-1:0]          lookup_pending_o
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Next-state of the pending vector: clears first, then the set overrides.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (sweep_en_i) begin
            pending_d[sweep_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
    end

    // Pending state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign query_pending_o = pending_q[query_addr_i];

    for (genvar p = 0; p < NUM_READ; p++) begin : g_lookup
        assign lookup_pending_o[p] = pending_q[lookup_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with same-cycle write-through bypass, a pending
// scoreboard for hazard detection, and a sequential clear sweep.
module scoreboard_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = RF_NUM_READ,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           regWrite,
    input  logic [ADDR_WIDTH-1:0]          writeAddr,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ-1:0]            readReady,
    input  logic                           reserveEn,
    input  logic [ADDR_WIDTH-1:0]          reserveAddr,
    output logic                           reserveAck,
    input  logic                           clearReq,
    output logic                           clearBusy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    rf_state_e             state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  idle;
    logic                  wr_en;
    logic                  res_pending;
    logic                  res_set;
    logic [NUM_READ-1:0]   rd_pending;

    assign idle = (state_q == ST_IDLE);

    // Register 0 is hardwired to zero when ZERO_REG is set: writes and
    // reservations to it never touch state.
    assign wr_en      = regWrite && idle && !((ZERO_REG != 0) && (writeAddr == '0));
    assign reserveAck = reserveEn && idle && !res_pending;
    assign res_set    = reserveAck && !((ZERO_REG != 0) && (reserveAddr == '0));
    assign clearBusy  = busy_q;

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .DEPTH      (DEPTH)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .set_en_i         (res_set),
        .set_addr_i       (reserveAddr),
        .clr_en_i         (wr_en),
        .clr_addr_i       (writeAddr),
        .sweep_en_i       (!idle),
        .sweep_addr_i     (idx_q),
        .query_addr_i     (reserveAddr),
        .query_pending_o  (res_pending),
        .lookup_addr_i    (readAddr),
        .lookup_pending_o (rd_pending)
    );

    // Clear FSM: one entry per cycle from index 0 up to DEPTH-1, then idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clearReq) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the array while clearing, otherwise writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (!idle) begin
            regs_q[idx_q] <= '0;
        end else if (wr_en) begin
            regs_q[writeAddr] <= writeData;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = readAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: hardwired zero, then same-cycle bypass, then storage.
        always_comb begin
            readData[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
            readReady[p] = !rd_pending[p];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                readData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                readReady[p] = 1'b1;
            end else if (regWrite && idle && (writeAddr == ra)) begin
                readData[p*DATA_WIDTH +: DATA_WIDTH] = writeData;
                readReady[p] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file with three read ports.
module tb_scoreboard_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic           clk;
    logic           rst;
    logic           regWrite;
    logic [AW-1:0]  writeAddr;
    logic [DW-1:0]  writeData;
    logic [NR*AW-1:0] readAddr;
    logic [NR*DW-1:0] readData;
    logic [NR-1:0]  readReady;
    logic           reserveEn;
    logic [AW-1:0]  reserveAddr;
    logic           reserveAck;
    logic           clearReq;
    logic           clearBusy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    scoreboard_register_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_READ   (NR),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .regWrite    (regWrite),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .readAddr    (readAddr),
        .readData    (readData),
        .readReady   (readReady),
        .reserveEn   (reserveEn),
        .reserveAddr (reserveAddr),
        .reserveAck  (reserveAck),
        .clearReq    (clearReq),
        .clearBusy   (clearBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return readData[p*DW +: DW];
    endfunction

    task automatic set_ra(input int a0, input int a1, input int a2);
        readAddr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        regWrite  = 1'b1;
        writeAddr = AW'(a);
        writeData = DW'(d);
    endtask

    initial begin
        rst = 1'b1; regWrite = 1'b0; writeAddr = '0; writeData = '0;
        reserveEn = 1'b0; reserveAddr = '0; clearReq = 1'b0;
        set_ra(1, 2, 3);
        #2;
        chk("reset_data0", rd(0), 0);
        chk("reset_data1", rd(1), 0);
        chk("reset_ready", readReady, 3'b111);
        chk("reset_busy", clearBusy, 0);
        tick();
        rst = 1'b0;

        // write with same-cycle bypass, then read from storage
        wr(1, 11); set_ra(1, 2, 1); #1;
        chk("bypass_r1", rd(0), 11);
        chk("bypass_r1_rdy", readReady[0], 1);
        tick();
        regWrite = 1'b0; #1;
        chk("stored_r1", rd(0), 11);

        // zero register ignores writes and never bypasses
        wr(0, 5); set_ra(0, 2, 1); #1;
        chk("r0_bypass", rd(0), 0);
        chk("r0_rdy", readReady[0], 1);
        tick();
        regWrite = 1'b0; #1;
        chk("r0_stored", rd(0), 0);

        // reservation and WAW refusal
        reserveEn = 1'b1; reserveAddr = 5'd2; set_ra(1, 2, 1); #1;
        chk("res_ack", reserveAck, 1);
        chk("res_rdy_same", readReady[1], 1);
        tick();
        chk("res_reack", reserveAck, 0);
        chk("res_rdy_next", readReady[1], 0);
        reserveEn = 1'b0;

        // writeback clears pending, bypass makes it ready that cycle
        wr(2, 12); #1;
        chk("wb_bypass_rdy", readReady[1], 1);
        chk("wb_bypass_data", rd(1), 12);
        tick();
        regWrite = 1'b0; #1;
        chk("wb_rdy_after", readReady[1], 1);
        chk("wb_data_after", rd(1), 12);
        reserveEn = 1'b1; reserveAddr = 5'd2; #1;
        chk("res_after_wb", reserveAck, 1);
        reserveEn = 1'b0;

        // reserve on r0 acks but leaves it ready
        reserveEn = 1'b1; reserveAddr = 5'd0; set_ra(0, 2, 1); #1;
        chk("res_r0_ack", reserveAck, 1);
        tick();
        reserveEn = 1'b0; #1;
        chk("res_r0_rdy", readReady[0], 1);

        // simultaneous write and reserve on a free register: reserve wins
        wr(4, 44); reserveEn = 1'b1; reserveAddr = 5'd4; set_ra(4, 2, 1); #1;
        chk("wr_res_ack", reserveAck, 1);
        tick();
        regWrite = 1'b0; reserveEn = 1'b0; #1;
        chk("wr_res_data", rd(0), 44);
        chk("wr_res_pend", readReady[0], 0);

        // asynchronous reset mid-stream
        rst = 1'b1; set_ra(1, 2, 4); #1;
        chk("rst_mid_d0", rd(0), 0);
        chk("rst_mid_d2", rd(2), 0);
        chk("rst_mid_rdy", readReady, 3'b111);
        tick();
        rst = 1'b0;

        // preload r1..r31 then sweep
        for (int i = 1; i < 32; i++) begin
            wr(i, 100 + i);
            tick();
        end
        regWrite = 1'b0; set_ra(31, 10, 3); #1;
        chk("preload_r31", rd(0), 131);
        clearReq = 1'b1; #1;
        chk("busy_before", clearBusy, 0);
        tick();
        clearReq = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40 && clearBusy; c++) begin
            cnt++;
            if (cnt == 5) begin
                wr(3, 333); reserveEn = 1'b1; reserveAddr = 5'd7; set_ra(3, 10, 3); #1;
                chk("sweep_no_bypass", rd(0), 0);
                chk("sweep_partial", rd(1), 110);
                chk("sweep_res_drop", reserveAck, 0);
            end else if (cnt == 10) begin
                clearReq = 1'b1;
            end
            tick();
            regWrite = 1'b0; reserveEn = 1'b0; clearReq = 1'b0;
        end
        chk("sweep_len", cnt, 32);
        for (int i = 0; i < 32; i++) begin
            set_ra(i, 0, 0); #1;
            chk("cleared", {i[15:0], rd(0)}, {i[15:0], 32'd0});
        end
        set_ra(7, 3, 0); #1;
        chk("cleared_rdy", readReady, 3'b111);

        // reset during sweep at cycle 10
        wr(5, 55); tick();
        wr(20, 77); tick();
        regWrite = 1'b0;
        clearReq = 1'b1; tick();
        clearReq = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        set_ra(5, 20, 0); #1;
        chk("pre_rst_r20", rd(1), 77);
        chk("pre_rst_busy", clearBusy, 1);
        rst = 1'b1; #1;
        chk("rst_sweep_busy", clearBusy, 0);
        chk("rst_sweep_r5", rd(0), 0);
        chk("rst_sweep_r20", rd(1), 0);
        tick();
        rst = 1'b0;
        clearReq = 1'b1; tick();
        clearReq = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40 && clearBusy; c++) begin
            cnt++;
            tick();
        end
        chk("resweep_len", cnt, 32);

        // three ports with bypass on two of them
        wr(2, 22); tick();
        wr(1, 99); set_ra(1, 2, 1); #1;
        chk("mp_p0", rd(0), 99);
        chk("mp_p1", rd(1), 22);
        chk("mp_p2", rd(2), 99);
        chk("mp_rdy", readReady, 3'b111);
        tick();
        regWrite = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
